// File: rtl/dm_cache_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// memory_sub_system_param
//   Shared geometry and state encoding for the direct-mapped cache controller.
//   Address layout is {tag, index, offset}; one valid bit per line.
//   Ports: none (package only).
// -----------------------------------------------------------------------------
package memory_sub_system_param;

    localparam int TAG_LENGTH      = 8;
    localparam int INDEX_LENGTH    = 4;
    localparam int OFFSET_LENGTH   = 4;
    localparam int NUM_CACHE_LINES = 1 << INDEX_LENGTH;
    localparam int ADDR_LENGTH     = TAG_LENGTH + INDEX_LENGTH + OFFSET_LENGTH;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COMPARE = 3'd1,
        ST_REFILL  = 3'd2,
        ST_WTHRU   = 3'd3,
        ST_DONE    = 3'd4
    } cache_state_t;

endpackage : memory_sub_system_param

// File: rtl/dm_cache_ctrl_valid.sv
// -----------------------------------------------------------------------------
// dm_valid_array
//   One valid flop per cache line. Single-index set, global clear,
//   combinational read.
//   Ports:
//     clk, resetn   clock / asynchronous active-low reset
//     set_i         set valid[set_idx_i] this cycle
//     set_idx_i     line to mark valid
//     clr_all_i     clear every line (takes priority over set_i)
//     rd_idx_i      line to look up
//     rd_valid_o    valid[rd_idx_i]
// -----------------------------------------------------------------------------
module dm_valid_array #(
    parameter int IDX_W     = 4,
    parameter int NUM_LINES = 1 << IDX_W
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             set_i,
    input  logic [IDX_W-1:0] set_idx_i,
    input  logic             clr_all_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic             rd_valid_o
);

    logic [NUM_LINES-1:0] valid_q;

    // NOTE: unlike a data array, the valid bits are control state and must be
    // reset; a line that powers up "valid" would return garbage as a hit.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q <= '0;
        end else if (clr_all_i) begin
            valid_q <= '0;
        end else if (set_i) begin
            valid_q[set_idx_i] <= 1'b1;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];

endmodule : dm_valid_array

// File: rtl/dm_cache_ctrl.sv
// -----------------------------------------------------------------------------
// dm_cache_ctrl
//   Sequencing FSM for a direct-mapped, write-through, no-write-allocate cache.
//   Accepts one CPU request at a time, looks the line up in an external
//   synchronous tag_mem, refills on read miss, writes through on every write,
//   then pulses cpu_ready for one cycle.
//
//   Optional build macro: CACHE_STATS_EN adds saturating hit_count/miss_count.
//
//   Ports:
//     clk, resetn                 clock / asynchronous active-low reset
//     cpu_req, cpu_we, cpu_addr   CPU request, held until cpu_ready
//     cpu_flush                   invalidate all lines (IDLE only, beats cpu_req)
//     cpu_ready, cpu_hit          one-cycle completion and its hit flag
//     tag_write/index/wdata       tag_mem control; tag_rdata returns 1 cycle later
//     data_write, data_src        data array write enable / source (0 CPU, 1 mem)
//     mem_req, mem_we, mem_addr   main-memory request, held until mem_ack
//     mem_ack                     one-cycle completion from main memory
//     hit_count, miss_count       (CACHE_STATS_EN only) request statistics
// -----------------------------------------------------------------------------
module dm_cache_ctrl
    import memory_sub_system_param::*;
#(
    parameter  int TAG_W     = TAG_LENGTH,
    parameter  int IDX_W     = INDEX_LENGTH,
    parameter  int OFF_W     = OFFSET_LENGTH,
    localparam int ADDR_W    = TAG_W + IDX_W + OFF_W,
    localparam int NUM_LINES = 1 << IDX_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_flush,
    output logic              cpu_ready,
    output logic              cpu_hit,
    output logic              tag_write,
    output logic [IDX_W-1:0]  tag_index,
    output logic [TAG_W-1:0]  tag_wdata,
    input  logic [TAG_W-1:0]  tag_rdata,
    output logic              data_write,
    output logic              data_src,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
`endif
);

    cache_state_t      state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic              hit_q, hit_d;
    // High in the first COMPARE cycle, while tag_mem is still reading.
    logic              tag_wait_q;

    logic [IDX_W-1:0]  idx_q;
    logic [TAG_W-1:0]  tag_q;
    logic              accept;
    logic              flush_now;
    logic              lookup_valid;
    logic              lookup_hit;
    logic              eval_cycle;
    logic              refill_done;

    assign idx_q = addr_q[OFF_W +: IDX_W];
    assign tag_q = addr_q[OFF_W+IDX_W +: TAG_W];

    assign flush_now   = (state_q == ST_IDLE) && cpu_flush;
    assign accept      = (state_q == ST_IDLE) && !cpu_flush && cpu_req;
    assign eval_cycle  = (state_q == ST_COMPARE) && !tag_wait_q;
    assign lookup_hit  = lookup_valid && (tag_rdata == tag_q);
    assign refill_done = (state_q == ST_REFILL) && mem_ack;

    dm_valid_array #(
        .IDX_W     (IDX_W),
        .NUM_LINES (NUM_LINES)
    ) u_valid (
        .clk        (clk),
        .resetn     (resetn),
        .set_i      (refill_done),
        .set_idx_i  (idx_q),
        .clr_all_i  (flush_now),
        .rd_idx_i   (idx_q),
        .rd_valid_o (lookup_valid)
    );

    // ---------------------------------------------------------------- state
    // NOTE: every flop is written with <= so all registers update from the
    // same pre-edge values; blocking assignments here would create ordering
    // races between blocks.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            we_q       <= 1'b0;
            hit_q      <= 1'b0;
            tag_wait_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            hit_q      <= hit_d;
            tag_wait_q <= accept;
        end
    end

    // ----------------------------------------------------------- next state
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (accept) state_d = ST_COMPARE;
            ST_COMPARE: begin
                if (!tag_wait_q) begin
                    if (we_q)            state_d = ST_WTHRU;
                    else if (lookup_hit) state_d = ST_DONE;
                    else                 state_d = ST_REFILL;
                end
            end
            ST_REFILL:  if (mem_ack) state_d = ST_DONE;
            ST_WTHRU:   if (mem_ack) state_d = ST_DONE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Request latch and registered lookup result.
    always_comb begin
        addr_d = addr_q;
        we_d   = we_q;
        hit_d  = hit_q;
        if (accept) begin
            addr_d = cpu_addr;
            we_d   = cpu_we;
        end
        if (eval_cycle) begin
            hit_d = lookup_hit;
        end
    end

    // -------------------------------------------------------------- outputs
    // Moore per state, except the COMPARE write-hit strobe and the refill
    // commit, which must line up with the cycle their condition is known.
    always_comb begin
        cpu_ready  = 1'b0;
        cpu_hit    = 1'b0;
        tag_write  = 1'b0;
        tag_index  = idx_q;
        tag_wdata  = tag_q;
        data_write = 1'b0;
        data_src   = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = addr_q;
        unique case (state_q)
            ST_IDLE: ;
            ST_COMPARE: begin
                // Write hit updates the cached copy; a write miss does not allocate.
                data_write = eval_cycle && we_q && lookup_hit;
            end
            ST_REFILL: begin
                mem_req  = 1'b1;
                data_src = 1'b1;
                if (mem_ack) begin
                    tag_write  = 1'b1;
                    data_write = 1'b1;
                end
            end
            ST_WTHRU: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
            end
            ST_DONE: begin
                cpu_ready = 1'b1;
                cpu_hit   = hit_q;
            end
            default: ;
        endcase
    end

`ifdef CACHE_STATS_EN
    // ----------------------------------------------------------- statistics
    logic [31:0] hit_count_q, miss_count_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else if (flush_now) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else if (state_q == ST_DONE) begin
            if (hit_q) begin
                if (hit_count_q != 32'hFFFF_FFFF) hit_count_q <= hit_count_q + 32'd1;
            end else begin
                if (miss_count_q != 32'hFFFF_FFFF) miss_count_q <= miss_count_q + 32'd1;
            end
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule : dm_cache_ctrl

// File: tb/tb_dm_cache_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dm_cache_ctrl
//   Directed bench for dm_cache_ctrl. Provides a synchronous tag_mem model
//   and a main-memory responder with a programmable ack delay. Inputs are
//   driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_dm_cache_ctrl;
    import memory_sub_system_param::*;

    localparam int TW = TAG_LENGTH;
    localparam int IW = INDEX_LENGTH;
    localparam int OW = OFFSET_LENGTH;
    localparam int AW = ADDR_LENGTH;

    logic          clk = 1'b0;
    logic          resetn;
    logic          cpu_req, cpu_we, cpu_flush;
    logic [AW-1:0] cpu_addr;
    logic          cpu_ready, cpu_hit;
    logic          tag_write;
    logic [IW-1:0] tag_index;
    logic [TW-1:0] tag_wdata, tag_rdata;
    logic          data_write, data_src;
    logic          mem_req, mem_we, mem_ack;
    logic [AW-1:0] mem_addr;
`ifdef CACHE_STATS_EN
    logic [31:0]   hit_count, miss_count;
`endif

    always #5 clk = ~clk;

    dm_cache_ctrl dut (
        .clk        (clk),
        .resetn     (resetn),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_flush  (cpu_flush),
        .cpu_ready  (cpu_ready),
        .cpu_hit    (cpu_hit),
        .tag_write  (tag_write),
        .tag_index  (tag_index),
        .tag_wdata  (tag_wdata),
        .tag_rdata  (tag_rdata),
        .data_write (data_write),
        .data_src   (data_src),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack)
`ifdef CACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    // Synchronous tag memory: read data appears one cycle after the index.
    logic [TW-1:0] tag_arr [1 << IW];
    initial begin
        for (int i = 0; i < (1 << IW); i++) tag_arr[i] = '0;
    end
    always @(posedge clk) begin
        if (tag_write) tag_arr[tag_index] <= tag_wdata;
        tag_rdata <= tag_arr[tag_index];
    end

    int n_cmp = 0;
    int n_err = 0;

    // Observations of the most recent run_req.
    int            r_lat;
    logic          r_hit, r_mreq, r_mwe, r_tw, r_dw, r_dw_src;
    logic [AW-1:0] r_maddr;
    logic [IW-1:0] r_tw_idx;
    logic [TW-1:0] r_tw_data;
    int            r_dw_cyc;

    function automatic logic [AW-1:0] mk_addr(input logic [TW-1:0] t, input logic [IW-1:0] ix,
                                              input logic [OW-1:0] off);
        return {t, ix, off};
    endfunction

    // Issue one request and observe the interface until cpu_ready (bounded).
    // r_lat counts falling edges from the accept edge to the one showing cpu_ready.
    task automatic run_req(input logic we, input logic [AW-1:0] addr, input int ack_delay,
                           input bit sync_first);
        int memwait;
        memwait = 0;
        r_lat = -1; r_hit = 1'bx; r_mreq = 0; r_mwe = 0; r_maddr = '0;
        r_tw = 0; r_tw_idx = '0; r_tw_data = '0; r_dw = 0; r_dw_src = 0; r_dw_cyc = -1;
        if (sync_first) @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (cpu_ready) begin
                r_lat = c; r_hit = cpu_hit; mem_ack = 1'b0;
                break;
            end
            mem_ack = 1'b0;
            if (data_write) begin r_dw = 1; r_dw_src = data_src; r_dw_cyc = c; end
            if (tag_write) begin r_tw = 1; r_tw_idx = tag_index; r_tw_data = tag_wdata; end
            if (mem_req) begin
                r_mreq = 1; r_maddr = mem_addr;
                if (mem_we) r_mwe = 1;
                if (memwait == ack_delay) begin
                    mem_ack = 1'b1;
                    #1;
                    if (data_write) begin r_dw = 1; r_dw_src = data_src; r_dw_cyc = c; end
                    if (tag_write) begin r_tw = 1; r_tw_idx = tag_index; r_tw_data = tag_wdata; end
                end else begin
                    memwait++;
                end
            end
        end
        cpu_req = 1'b0;
        mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_flush = 0; mem_ack = 0;
        repeat (3) @(negedge clk);
        n_cmp++; if (cpu_ready !== 1'b0) begin n_err++; $display("FAIL reset_cpu_ready got=%b exp=0", cpu_ready); end
        n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
        n_cmp++; if ({tag_write, data_write, mem_we, data_src, cpu_hit} !== 5'b0) begin
            n_err++; $display("FAIL reset_strobes got=%b exp=00000", {tag_write, data_write, mem_we, data_src, cpu_hit}); end
        n_cmp++; if (mem_addr !== '0) begin n_err++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
        n_cmp++; if (tag_index !== '0 || tag_wdata !== '0) begin
            n_err++; $display("FAIL reset_tag_bus got idx=%h wdata=%h exp=0/0", tag_index, tag_wdata); end
        resetn = 1'b1;
    endtask

    task automatic test_read_miss();
        logic [AW-1:0] a;
        a = mk_addr(8'h03, 4'd5, 4'h8);
        run_req(1'b0, a, 2, 1'b1);
        n_cmp++; if (r_lat !== 6) begin n_err++; $display("FAIL rmiss_latency got=%0d exp=6", r_lat); end
        n_cmp++; if (r_hit !== 1'b0) begin n_err++; $display("FAIL rmiss_hit got=%b exp=0", r_hit); end
        n_cmp++; if (r_mreq !== 1'b1 || r_mwe !== 1'b0) begin
            n_err++; $display("FAIL rmiss_mem got req=%b we=%b exp=1/0", r_mreq, r_mwe); end
        n_cmp++; if (r_maddr !== a) begin n_err++; $display("FAIL rmiss_mem_addr got=%h exp=%h", r_maddr, a); end
        n_cmp++; if (r_tw !== 1'b1 || r_tw_idx !== 4'd5 || r_tw_data !== 8'h03) begin
            n_err++; $display("FAIL rmiss_tag_write got w=%b idx=%0d data=%h exp=1/5/03", r_tw, r_tw_idx, r_tw_data); end
        n_cmp++; if (r_dw !== 1'b1 || r_dw_src !== 1'b1) begin
            n_err++; $display("FAIL rmiss_data_write got w=%b src=%b exp=1/1", r_dw, r_dw_src); end
    endtask

    task automatic test_read_hit();
        // Different offset in the same line must still hit.
        run_req(1'b0, mk_addr(8'h03, 4'd5, 4'h2), 0, 1'b1);
        n_cmp++; if (r_lat !== 3) begin n_err++; $display("FAIL rhit_latency got=%0d exp=3", r_lat); end
        n_cmp++; if (r_hit !== 1'b1) begin n_err++; $display("FAIL rhit_hit got=%b exp=1", r_hit); end
        n_cmp++; if (r_mreq !== 1'b0 || r_tw !== 1'b0 || r_dw !== 1'b0) begin
            n_err++; $display("FAIL rhit_side_effects got mreq=%b tw=%b dw=%b exp=0/0/0", r_mreq, r_tw, r_dw); end
    endtask

    task automatic test_write_hit();
        run_req(1'b1, mk_addr(8'h03, 4'd5, 4'h4), 1, 1'b1);
        n_cmp++; if (r_lat !== 5) begin n_err++; $display("FAIL whit_latency got=%0d exp=5", r_lat); end
        n_cmp++; if (r_hit !== 1'b1) begin n_err++; $display("FAIL whit_hit got=%b exp=1", r_hit); end
        n_cmp++; if (r_dw !== 1'b1 || r_dw_src !== 1'b0 || r_dw_cyc !== 2) begin
            n_err++; $display("FAIL whit_data_write got w=%b src=%b cyc=%0d exp=1/0/2", r_dw, r_dw_src, r_dw_cyc); end
        n_cmp++; if (r_mreq !== 1'b1 || r_mwe !== 1'b1 || r_tw !== 1'b0) begin
            n_err++; $display("FAIL whit_mem got req=%b we=%b tw=%b exp=1/1/0", r_mreq, r_mwe, r_tw); end
    endtask

    task automatic test_write_miss();
        run_req(1'b1, mk_addr(8'h01, 4'd2, 4'h4), 0, 1'b1);
        n_cmp++; if (r_lat !== 4 || r_hit !== 1'b0) begin
            n_err++; $display("FAIL wmiss_done got lat=%0d hit=%b exp=4/0", r_lat, r_hit); end
        n_cmp++; if (r_tw !== 1'b0 || r_dw !== 1'b0) begin
            n_err++; $display("FAIL wmiss_no_alloc got tw=%b dw=%b exp=0/0", r_tw, r_dw); end
        n_cmp++; if (r_mwe !== 1'b1) begin n_err++; $display("FAIL wmiss_mem_we got=%b exp=1", r_mwe); end
        run_req(1'b0, mk_addr(8'h01, 4'd2, 4'h0), 0, 1'b1);
        n_cmp++; if (r_hit !== 1'b0 || r_mreq !== 1'b1 || r_mwe !== 1'b0) begin
            n_err++; $display("FAIL wmiss_then_read got hit=%b mreq=%b mwe=%b exp=0/1/0", r_hit, r_mreq, r_mwe); end
    endtask

    task automatic test_flush_with_req();
        @(negedge clk);
        cpu_flush = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = mk_addr(8'h03, 4'd5, 4'h0);
        @(negedge clk);
        cpu_flush = 1'b0;
        // Flush must win: the request is accepted only on the following edge.
        run_req(1'b0, mk_addr(8'h03, 4'd5, 4'h0), 0, 1'b0);
        n_cmp++; if (r_lat !== 4) begin n_err++; $display("FAIL flush_req_latency got=%0d exp=4", r_lat); end
        n_cmp++; if (r_hit !== 1'b0 || r_mreq !== 1'b1) begin
            n_err++; $display("FAIL flush_invalidates got hit=%b mreq=%b exp=0/1", r_hit, r_mreq); end
    endtask

    task automatic test_boundary();
        run_req(1'b0, mk_addr(8'hFF, 4'd0, 4'hF), 0, 1'b1);
        n_cmp++; if (r_hit !== 1'b0 || r_tw_idx !== 4'd0 || r_tw_data !== 8'hFF) begin
            n_err++; $display("FAIL idx0_miss got hit=%b idx=%0d data=%h exp=0/0/ff", r_hit, r_tw_idx, r_tw_data); end
        run_req(1'b0, mk_addr(8'hFF, 4'd0, 4'h0), 0, 1'b1);
        n_cmp++; if (r_hit !== 1'b1 || r_lat !== 3) begin
            n_err++; $display("FAIL idx0_hit got hit=%b lat=%0d exp=1/3", r_hit, r_lat); end
        run_req(1'b0, mk_addr(8'hFF, 4'd15, 4'h0), 1, 1'b1);
        n_cmp++; if (r_hit !== 1'b0 || r_tw_idx !== 4'd15) begin
            n_err++; $display("FAIL idx15_miss got hit=%b idx=%0d exp=0/15", r_hit, r_tw_idx); end
        run_req(1'b0, mk_addr(8'hFF, 4'd15, 4'h7), 0, 1'b1);
        n_cmp++; if (r_hit !== 1'b1) begin n_err++; $display("FAIL idx15_hit got=%b exp=1", r_hit); end
        // Same line, other tag: must miss on tag compare alone.
        run_req(1'b0, mk_addr(8'h7E, 4'd0, 4'h0), 0, 1'b1);
        n_cmp++; if (r_hit !== 1'b0 || r_tw_data !== 8'h7E) begin
            n_err++; $display("FAIL tag_conflict got hit=%b data=%h exp=0/7e", r_hit, r_tw_data); end
`ifdef CACHE_STATS_EN
        // Since the flush: misses idx5, idx0, idx15, idx0/7E; hits idx0, idx15.
        n_cmp++; if (hit_count !== 32'd2 || miss_count !== 32'd4) begin
            n_err++; $display("FAIL stats got hit=%0d miss=%0d exp=2/4", hit_count, miss_count); end
`endif
    endtask

    task automatic test_reset_mid_refill();
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = mk_addr(8'h9C, 4'd7, 4'h0);
        repeat (3) @(negedge clk);
        n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL mid_refill_started got=%b exp=1", mem_req); end
        cpu_req = 1'b0;
        #2 resetn = 1'b0;
        #1;
        n_cmp++; if (mem_req !== 1'b0 || cpu_ready !== 1'b0 || mem_addr !== '0) begin
            n_err++; $display("FAIL async_reset got mreq=%b rdy=%b addr=%h exp=0/0/0", mem_req, cpu_ready, mem_addr); end
        @(negedge clk);
        resetn = 1'b1;
        mem_ack = 1'b1;
        #1;
        n_cmp++; if (tag_write !== 1'b0 || data_write !== 1'b0) begin
            n_err++; $display("FAIL stale_ack got tw=%b dw=%b exp=0/0", tag_write, data_write); end
        @(negedge clk);
        mem_ack = 1'b0;
        n_cmp++; if (mem_req !== 1'b0 || cpu_ready !== 1'b0) begin
            n_err++; $display("FAIL stale_ack_idle got mreq=%b rdy=%b exp=0/0", mem_req, cpu_ready); end
        // Reset also cleared every valid bit: idx5 misses again.
        run_req(1'b0, mk_addr(8'h03, 4'd5, 4'h0), 0, 1'b1);
        n_cmp++; if (r_hit !== 1'b0 || r_lat !== 4) begin
            n_err++; $display("FAIL post_reset_read got hit=%b lat=%0d exp=0/4", r_hit, r_lat); end
    endtask

    initial begin
        test_reset();
        test_read_miss();
        test_read_hit();
        test_write_hit();
        test_write_miss();
        test_flush_with_req();
        test_boundary();
        test_reset_mid_refill();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_dm_cache_ctrl
